dmem_mmio_ctrl: RTL

//  Data-side memory and MMIO target that sits directly downstream of the pipelined RV32I core's MEM stage.

---
 rtl/dmem_mmio_ctrl.sv | 83 ++++++++
 1 files changed

// File: rtl/dmem_mmio_ctrl.sv
// dmem_mmio_ctrl: data-side RAM plus MMIO window (TX byte FIFO, status, cycle counter) behind the RV32I MEM stage
//  clk      in   core clock, all state on posedge
//  rst      in   asynchronous reset, active-low
//  daddr    in   byte address (bits [1:0] ignored)
//  we       in   byte-lane write enables, 0 = read/idle
//  dwdata   in   lane-aligned write data
//  drdata   out  combinational read data for daddr
//  tx_data  out  FIFO head byte, 0 when empty
//  tx_valid out  FIFO not empty
//  tx_ready in   consumer pops head when tx_valid & tx_ready
//  Define MMIO_CYCLE_CNT_EN to build the CYCLE counter; otherwise CYCLE reads 0.
module dmem_mmio_ctrl #(
  parameter int          RAM_AW    = 10,
  parameter int          FIFO_AW   = 3,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] daddr,
  input  logic [3:0]  we,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  logic [31:0] mem [2**RAM_AW];
  logic [7:0] fifo [2**FIFO_AW];
  logic [FIFO_AW:0] wp, rp, count;
  logic ovf, empty, full, ram_hit, mmio_hit, push, pop, clr, accept;
  logic [1:0] sel, unused_lsb;
  logic [RAM_AW-1:0] idx;
  logic [31:0] status, cyc_rd;
  assign unused_lsb = daddr[1:0];
  assign ram_hit = daddr[31:RAM_AW+2] == '0;
  assign mmio_hit = daddr[31:4] == MMIO_BASE[31:4];
  assign sel = daddr[3:2];
  assign idx = daddr[RAM_AW+1:2];
  assign empty = wp == rp;
  // pointers carry one extra wrap bit so full and empty are distinguishable
  assign full = (wp ^ rp) == {1'b1, {FIFO_AW{1'b0}}};
  assign count = wp - rp;
  assign tx_valid = !empty;
  assign tx_data = empty ? 8'h00 : fifo[rp[FIFO_AW-1:0]];
  assign pop = tx_valid & tx_ready;
  assign push = mmio_hit && sel == 2'd0 && we[0];
  // a pop in the same cycle frees the slot the push lands in
  assign accept = push && (!full || pop);
  assign clr = mmio_hit && sel == 2'd1 && |we && dwdata[18];
  always_comb begin
    status = '0;
    status[FIFO_AW:0] = count;
    status[16] = empty;
    status[17] = full;
    status[18] = ovf;
  end
  assign drdata = ram_hit ? mem[idx] : !mmio_hit ? 32'h0 : sel == 2'd1 ? status : sel == 2'd2 ? cyc_rd : 32'h0;
  always_ff @(posedge clk)
    if (ram_hit)
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[idx][8*i +: 8] <= dwdata[8*i +: 8];
  always_ff @(posedge clk)
    if (accept) fifo[wp[FIFO_AW-1:0]] <= dwdata[7:0];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      ovf <= 1'b0;
    end else begin
      if (pop) rp <= rp + 1'b1;
      if (accept) wp <= wp + 1'b1;
      ovf <= (push && full && !pop) ? 1'b1 : clr ? 1'b0 : ovf;
    end
`ifdef MMIO_CYCLE_CNT_EN
  logic [31:0] cyc;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cyc <= '0;
    else cyc <= cyc + 32'd1;
  assign cyc_rd = cyc;
`else
  assign cyc_rd = 32'h0;
`endif
endmodule
